// File: rtl/gpr_pkg.sv
// Shared types and helpers for the banked GPR file.
// Holds the scrub state encoding and alias target resolution.
package gpr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCRUB,
    DONE
  } scrub_state_e;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Targets 0..nregs-1 are array entries.
  // Target nregs+b-1 is alias bank register b.
  function automatic int alias_tgt(
    input int   addr,
    input int   bnk,
    input logic no_alias,
    input int   alias_reg,
    input int   nregs,
    input int   nbank
  );
    int b;
    b = (bnk >= nbank) ? nbank - 1 : bnk;
    if (b != 0 && !no_alias && addr == alias_reg)
      return nregs + b - 1;
    return addr;
  endfunction

endpackage

// File: rtl/gpr_scrub_fsm.sv
// Scrub sequencer: walks ptr over r1..rNREGS-1.
// It emits one array clear per enabled cycle.
module gpr_scrub_fsm
  import gpr_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en_i,
  input  logic          req_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          clr_vld_o,
  output logic [AW-1:0] clr_idx_o
);

  scrub_state_e  state_q;
  logic [AW-1:0] ptr_q;
  logic          busy_q;
  logic          done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clk_en_i) begin
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            state_q <= SCRUB;
            ptr_q   <= AW'(1);
            busy_q  <= 1'b1;
          end
        end
        SCRUB: begin
          if (ptr_q == AW'(NREGS - 1)) begin
            state_q <= DONE;
            ptr_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= ptr_q + AW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign clr_vld_o = (state_q == SCRUB);
  assign clr_idx_o = ptr_q;

endmodule

// File: rtl/gpr_bank_file.sv
// Integer register file with banked alias register,
// ordered multi-port writes and hardware scrub.
module gpr_bank_file
  import gpr_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREGS     = NREGS_DEF,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 2,
  parameter int ALIAS_REG = NREGS - 1,
  parameter int NBANK     = 2,
  localparam int AW       = $clog2(NREGS),
  localparam int BW       = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic [BW-1:0]          bank,
  input  logic [NREAD*AW-1:0]    raddr,
  input  logic [NREAD-1:0]       read_no_alias,
  output logic [NREAD*XLEN-1:0]  rdata,
  input  logic [NWRITE-1:0]      wen,
  input  logic [NWRITE*AW-1:0]   waddr,
  input  logic [NWRITE*XLEN-1:0] wdata,
  input  logic [NWRITE-1:0]      write_no_alias,
  input  logic                   scrub_req,
  output logic                   scrub_busy,
  output logic                   scrub_done,
  output logic [XLEN-1:0]        ret_val
);

  // Array entries and bank registers share one target space.
  localparam int NT = NREGS + NBANK - 1;
  localparam int TW = $clog2(NT);

  logic [XLEN-1:0] regs_q [NT];
  logic [XLEN-1:0] regs_d [NT];
  logic [XLEN-1:0] rdata_q [NREAD];
  logic [XLEN-1:0] rdata_d [NREAD];
  logic [TW-1:0]   wtgt [NWRITE];
  logic [TW-1:0]   rtgt [NREAD];
  logic [TW-1:0]   clr_tgt;
  logic            clr_vld;
  logic [AW-1:0]   clr_idx;

  gpr_scrub_fsm #(.NREGS(NREGS)) u_scrub (
    .clk       (clk),
    .rst       (rst),
    .clk_en_i  (clk_en),
    .req_i     (scrub_req),
    .busy_o    (scrub_busy),
    .done_o    (scrub_done),
    .clr_vld_o (clr_vld),
    .clr_idx_o (clr_idx)
  );

  assign clr_tgt = TW'(clr_idx);

  always_comb begin
    for (int p = 0; p < NWRITE; p++)
      wtgt[p] = TW'(alias_tgt(int'(waddr[p*AW +: AW]),
        int'(bank), write_no_alias[p], ALIAS_REG, NREGS, NBANK));
    for (int i = 0; i < NREAD; i++)
      rtgt[i] = TW'(alias_tgt(int'(raddr[i*AW +: AW]),
        int'(bank), read_no_alias[i], ALIAS_REG, NREGS, NBANK));
  end

  always_comb begin
    regs_d = regs_q;
    if (clr_vld)
      regs_d[clr_tgt] = '0;
    for (int p = 0; p < NWRITE; p++)
      if (wen[p])
        regs_d[wtgt[p]] = wdata[p*XLEN +: XLEN];
    regs_d[0] = '0;
  end

  always_comb begin
    for (int i = 0; i < NREAD; i++) begin
      rdata_d[i] = regs_q[rtgt[i]];
      if (clr_vld && clr_tgt == rtgt[i])
        rdata_d[i] = '0;
      for (int p = 0; p < NWRITE; p++)
        if (wen[p] && wtgt[p] == rtgt[i])
          rdata_d[i] = wdata[p*XLEN +: XLEN];
      if (rtgt[i] == '0)
        rdata_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NT; k++)
        regs_q[k] <= '0;
      for (int i = 0; i < NREAD; i++)
        rdata_q[i] <= '0;
    end else if (clk_en) begin
      regs_q  <= regs_d;
      rdata_q <= rdata_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    assign rdata[i*XLEN +: XLEN] = rdata_q[i];
  end

  assign ret_val = regs_q[1];

endmodule

// File: tb/tb_gpr_bank_file.sv
// Directed bench for gpr_bank_file (NBANK=3 build).
// Expected values are hand-computed constants.
module tb_gpr_bank_file;

  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [1:0]  bank = '0;
  logic [9:0]  raddr = '0;
  logic [1:0]  read_no_alias = '0;
  logic [63:0] rdata;
  logic [1:0]  wen = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  write_no_alias = '0;
  logic        scrub_req = 1'b0;
  logic        scrub_busy;
  logic        scrub_done;
  logic [31:0] ret_val;

  int n_chk = 0;
  int n_fail = 0;

  gpr_bank_file #(.NBANK(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .bank           (bank),
    .raddr          (raddr),
    .read_no_alias  (read_no_alias),
    .rdata          (rdata),
    .wen            (wen),
    .waddr          (waddr),
    .wdata          (wdata),
    .write_no_alias (write_no_alias),
    .scrub_req      (scrub_req),
    .scrub_busy     (scrub_busy),
    .scrub_done     (scrub_done),
    .ret_val        (ret_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int port, input int a);
    raddr[port*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int port, input int a, input logic [31:0] d);
    wen[port] = 1'b1;
    waddr[port*AW +: AW] = AW'(a);
    wdata[port*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int done_cnt;
    int cycles;
    logic done_seen;

    repeat (2) cyc();
    chk("rst_rd0", rdata[31:0], 32'h0);
    chk("rst_rd1", rdata[63:32], 32'h0);
    chk("rst_busy", 32'(scrub_busy), 32'h0);
    chk("rst_done", 32'(scrub_done), 32'h0);
    chk("rst_ret", ret_val, 32'h0);
    rst = 1'b0;

    rd(0, 0); rd(1, 5);
    cyc();
    chk("r0", rdata[31:0], 32'h0);
    chk("r5", rdata[63:32], 32'h0);
    rd(1, 31);
    cyc();
    chk("r31", rdata[63:32], 32'h0);

    wr(0, 7, 32'h1111_1111);
    wr(1, 7, 32'h2222_2222);
    rd(0, 7);
    cyc();
    wen = '0;
    chk("wprio_fwd", rdata[31:0], 32'h2222_2222);
    cyc();
    chk("wprio_store", rdata[31:0], 32'h2222_2222);

    bank = 2'd2;
    wr(0, 31, 32'h0000_BEEF);
    cyc();
    wen = '0;
    bank = 2'd1;
    rd(0, 31); rd(1, 31);
    read_no_alias = 2'b10;
    cyc();
    chk("b1_empty", rdata[31:0], 32'h0);
    chk("arr31_empty", rdata[63:32], 32'h0);
    bank = 2'd3;
    cyc();
    chk("b3_clamp", rdata[31:0], 32'h0000_BEEF);
    chk("arr31_b3", rdata[63:32], 32'h0);

    bank = 2'd1;
    wr(0, 31, 32'hA000_0000);
    cyc();
    bank = 2'd0;
    wr(0, 31, 32'h0000_1234);
    cyc();
    wen = '0;
    bank = 2'd1;
    read_no_alias = 2'b10;
    cyc();
    chk("b1_alias", rdata[31:0], 32'hA000_0000);
    chk("b1_noalias", rdata[63:32], 32'h0000_1234);
    read_no_alias = 2'b01;
    cyc();
    chk("p0_noalias", rdata[31:0], 32'h0000_1234);
    chk("p1_alias", rdata[63:32], 32'hA000_0000);

    read_no_alias = '0;
    bank = 2'd0;
    clk_en = 1'b0;
    wr(0, 9, 32'h99);
    rd(0, 9);
    cyc();
    chk("cen_hold", rdata[31:0], 32'h0000_1234);
    clk_en = 1'b1;
    wen = '0;
    cyc();
    chk("cen_nowr", rdata[31:0], 32'h0);

    for (int i = 1; i < 32; i++) begin
      wr(0, i, 32'(i));
      cyc();
    end
    wen = '0;
    chk("fill_ret", ret_val, 32'd1);
    rd(0, 31);
    cyc();
    chk("fill_r31", rdata[31:0], 32'd31);

    scrub_req = 1'b1;
    cyc();
    scrub_req = 1'b0;
    chk("scr_busy", 32'(scrub_busy), 32'h1);
    n = 1;
    done_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (n == 20) wr(0, 20, 32'h55);
      else wen = '0;
      cyc();
      if (scrub_done) done_cnt++;
      if (!scrub_busy) break;
      n++;
    end
    wen = '0;
    chk("scr_len", 32'(n), 32'd32);
    chk("scr_done", 32'(done_cnt), 32'd1);

    for (int i = 0; i < 32; i++) begin
      rd(0, i); rd(1, i);
      cyc();
      chk($sformatf("scr_r%0d_p0", i), rdata[31:0],
          (i == 20) ? 32'h55 : 32'h0);
      chk($sformatf("scr_r%0d_p1", i), rdata[63:32],
          (i == 20) ? 32'h55 : 32'h0);
    end
    bank = 2'd1;
    rd(0, 31);
    cyc();
    chk("scr_b1", rdata[31:0], 32'hA000_0000);
    bank = 2'd2;
    cyc();
    chk("scr_b2", rdata[31:0], 32'h0000_BEEF);
    bank = 2'd0;

    scrub_req = 1'b1;
    cyc();
    scrub_req = 1'b0;
    cycles = 0;
    done_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      clk_en = (k % 2 == 1);
      cyc();
      cycles++;
      if (scrub_done) done_cnt++;
      if (!scrub_busy) break;
    end
    clk_en = 1'b1;
    chk("tog_len", 32'(cycles), 32'd64);
    chk("tog_done", 32'(done_cnt), 32'd2);

    bank = 2'd0;
    wr(0, 5, 32'h77);
    cyc();
    wen = '0;
    scrub_req = 1'b1;
    cyc();
    scrub_req = 1'b0;
    repeat (9) cyc();
    chk("mid_busy", 32'(scrub_busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(scrub_busy), 32'h0);
    done_seen = scrub_done;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      done_seen = done_seen | scrub_done;
    end
    chk("rst_mid_done", 32'(done_seen), 32'h0);
    chk("rst_mid_ret", ret_val, 32'h0);
    bank = 2'd1;
    rd(0, 20); rd(1, 31);
    cyc();
    chk("rst_r20", rdata[31:0], 32'h0);
    chk("rst_b1", rdata[63:32], 32'h0);
    bank = 2'd2;
    cyc();
    chk("rst_b2", rdata[63:32], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_bank_file.md
# gpr_bank_file

Parametrised successor to the integer register file: NREAD synchronous read ports, NWRITE write ports with ordered priority, and NBANK banked copies of the alias register (stack pointer per privilege bank) instead of a single kernel alias. Adds asynchronous reset and a hardware scrub sequencer that clears the GPR array one register per enabled cycle for context-switch hygiene. It sits between decode (reads) and writeback (writes) in the integer pipeline; the cregfile supplies `bank`.

## Interface
- XLEN, 32, data width
- NREGS, 32, architectural registers (power of two, ≥4); AW = clog2(NREGS)
- NREAD, 2, read ports
- NWRITE, 2, write ports; higher index = later in program order
- ALIAS_REG, NREGS-1, register index that is banked
- NBANK, 2, alias banks; bank 0 = plain array entry, banks 1..NBANK-1 = separate registers; BW = max(1, clog2(NBANK))

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clk_en  in  1  CPU cycle enable; all state holds when low
- bank  in  BW  active alias bank (0 = user)
- raddr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- read_no_alias  in  NREAD  per-port: ALIAS_REG reads the array, not the bank
- rdata  out  NREAD*XLEN  registered read data
- wen  in  NWRITE  write enables
- waddr  in  NWRITE*AW  write addresses
- wdata  in  NWRITE*XLEN  write data
- write_no_alias  in  NWRITE  per-port alias suppression
- scrub_req  in  1  start scrub (sampled when idle)
- scrub_busy  out  1  scrub in progress
- scrub_done  out  1  one-cycle completion pulse
- ret_val  out  XLEN  array entry r1 (combinational, test visibility)

## Operation
- Register 0 reads zero; writes to 0 are dropped.
- Target resolution per access: if bank≠0, !no_alias, addr==ALIAS_REG, then target = bank register `bank`; else array[addr]. A bank value ≥ NBANK selects bank NBANK-1.
- Writes: same target from several ports → highest-index enabled port wins.
- Reads: rdata_i <= forwarded value. Priority: highest-index write port hitting the same resolved target, then scrub clear of that target (value 0), then stored value.
- Scrub FSM: IDLE → SCRUB on clk_en && scrub_req; ptr starts at 1. In SCRUB, each enabled cycle clears array[ptr], ptr++. After ptr==NREGS-1 → DONE (scrub_done=1 for one enabled cycle) → IDLE. scrub_req ignored outside IDLE.
- Scrub never touches bank registers 1..NBANK-1.
- A port write to array[ptr] in the same cycle as its scrub clear wins (written value stored). Writes to already-scrubbed registers persist.
- rst mid-scrub: FSM to IDLE, no scrub_done.

## Timing
- Reset values: all array entries, bank registers, rdata, ptr = 0; FSM IDLE; scrub_busy=0, scrub_done=0; ret_val=0.
- Read latency: 1 enabled cycle; same-cycle write data visible through forwarding.
- clk_en low: no writes, no read update, FSM and ptr frozen, scrub_done held.
- Scrub duration: NREGS-1 enabled cycles in SCRUB plus 1 in DONE; scrub_busy high in SCRUB and DONE.
- `bank` change takes effect on the next enabled edge for both reads and writes.

## Structure
- Shared package gpr_pkg: scrub state enum (IDLE, SCRUB, DONE), default XLEN/NREGS constants, ALIAS target-resolution function.
- One sub-module: gpr_scrub_fsm (state, ptr, busy/done, per-cycle clear index and valid). Array, banks and forwarding stay in the top.

## Test plan
- Reset then read r0, r5, r31 on both ports → all 0; scrub_busy=0.
- Ports 0 and 1 write r7 = 0x11111111 / 0x22222222 in one cycle, port 0 reads r7 that same cycle → rdata0=0x22222222 next cycle; r7 stored as 0x22222222.
- bank=1: write r31=0xA000_0000 via port 0; bank=0: write r31=0x1234; read r31 with bank=1 → 0xA000_0000; bank=1 with read_no_alias=1 → 0x1234.
- NBANK=3: bank=2 write r31=0xBEEF, bank=1 read r31 → 0; bank=3 read r31 → 0xBEEF.
- Fill r1..r31 with index value, pulse scrub_req → busy for 32 enabled cycles, done pulse once; all reads 0 except bank-1 r31; a port write r20=0x55 at ptr==20 survives.
- Scrub with clk_en toggling every other cycle → duration doubles; assert rst at ptr==10 → busy drops immediately, scrub_done never asserts, all registers 0.
